fifo_uart_tx: RTL
=================

Name: fifo_uart_tx

Overview:
- Read-side consumer of the 4-deep byte FIFO. Drains bytes via the FIFO's pop/empty/r_data interface and serializes each byte onto a UART line as 8N1, LSB first.
- Owns its baud tick generation.
- Sits between the TX FIFO and the board TX pin. The FIFO's push side is driven by the application.

Parameters:
- BAUD_DIV, 651: clock cycles per oversample tick (100 MHz / (9600*16), truncated).
- OVERSAMPLE, 16: ticks per UART bit.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rdata  in  8  FIFO read data. Combinational; valid whenever fifo_empty=0.
- fifo_pop  out  1  one-cycle pop strobe to the FIFO.
- tx  out  1  serial line. Registered; idle high.
- tx_busy  out  1  high while a frame is in progress (START/DATA/STOP).
- tx_done  out  1  one-cycle pulse at the end of each stop bit.

Behaviour:
- Reset (async, rst=1): state=IDLE, tx=1, fifo_pop=0, tx_busy=0, tx_done=0, shift register=0, bit/tick/divider counters=0. Reset mid-frame aborts the frame immediately; tx returns high with no partial stop bit.
- Baud tick:
  - Divider counts 0..BAUD_DIV-1 and asserts tick when the count equals BAUD_DIV-1.
  - Divider is held at 0 in IDLE. Every bit therefore lasts exactly OVERSAMPLE*BAUD_DIV clocks, measured from the START entry edge.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1.
  - If fifo_empty=0: fifo_pop=1 combinationally in this cycle, fifo_rdata is latched into the shift register on the same edge, and state goes to START.
  - fifo_pop is never asserted when fifo_empty=1 or outside IDLE.
- START:
  - tx=0.
  - After OVERSAMPLE ticks: state goes to DATA, bit count=0.
- DATA:
  - tx = shift register bit 0.
  - After OVERSAMPLE ticks: shift right by one and increment bit count.
  - After bit 7 completes: state goes to STOP.
- STOP:
  - tx=1.
  - After OVERSAMPLE ticks: state goes to IDLE and tx_done=1 for exactly one clock, concurrent with the IDLE entry edge.
- tx is a registered output, driven from the next-state value. The first START low appears on the edge that leaves IDLE, i.e. the same edge that latches data and on which the FIFO sees the pop.
- Back-to-back frames: when the FIFO is still non-empty after a frame, the next pop occurs in the first IDLE cycle after STOP. Gap between frames is exactly 1 clock of idle-high.
- Frame length: 10*OVERSAMPLE*BAUD_DIV clocks.
- Data is captured at pop time. Later FIFO pushes or pointer changes do not affect the frame in flight.
- fifo_empty rising mid-frame is ignored. It is sampled only in IDLE.
- Counter widths:
  - tick count: clog2(OVERSAMPLE).
  - bit count: 3 bits.
  - divider: clog2(BAUD_DIV).
  - Counters wrap explicitly to 0 at their terminal values.

Decomposition:
- Shared package (uart_pkg): state encodings (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3), DATA_BITS=8, default OVERSAMPLE and BAUD_DIV.
- One sub-module: baud_tick_gen, with ports clk, rst, en, tick. It is also reusable by the matching receiver.
- The FSM and shifter live in fifo_uart_tx.

Test Plan (all use BAUD_DIV=2, OVERSAMPLE=16, so 32 clocks/bit and 320 clocks/frame):
1. Reset with FIFO empty: hold for 500 clocks -> tx=1, fifo_pop=0, tx_busy=0, tx_done never pulses.
2. Single byte 8'hA5 pushed into FIFO -> exactly one fifo_pop cycle.
   - tx sequence, 32 clocks each: 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop).
   - tx_done pulses once at clock 320 after the pop edge.
   - tx_busy is high for 320 clocks.
3. Four bytes 8'h01,8'h80,8'hFF,8'h00 pushed until the FIFO is full -> four frames in order.
   - Each frame is 320 clocks, with exactly a 1-clock idle gap between frames.
   - Exactly 4 pops; fifo_empty=1 after the 4th pop.
4. Push 8'h3C, then push 8'hC3 at clock 100 of the first frame -> first frame still carries 3C.
   - 8'hC3 is popped in the IDLE cycle after tx_done.
   - No pop is issued during the frame.
5. Reset asserted at clock 150 of a frame of 8'h55 -> tx=1 and tx_busy=0 asynchronously.
   - After release with the FIFO empty, no further pop and no tx_done.
6. fifo_empty=1 held while fifo_rdata toggles randomly -> fifo_pop stays 0 and tx stays 1 throughout.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings and default timing constants
package uart_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int DATA_BITS          = 8;
    localparam int OVERSAMPLE_DEFAULT = 16;
    localparam int BAUD_DIV_DEFAULT   = 651;

endpackage

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - oversample tick divider, held at zero while disabled
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int              DIV_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BAUD_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    assign tick = en && (div_cnt == DIV_LAST);

    // Clearing while disabled aligns every bit period to the frame's first edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (!en || (div_cnt == DIV_LAST)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - drains a byte FIFO and serializes each byte as 8N1, LSB first
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = BAUD_DIV_DEFAULT,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rdata,
    output logic       fifo_pop,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int                TICK_W    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

    logic [1:0]           state, state_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [TICK_W-1:0]    tick_cnt, tick_cnt_n;
    logic [2:0]           bit_cnt, bit_cnt_n;
    logic                 tick, bit_end, baud_en, done_n, tx_n;

    assign baud_en  = (state != ST_IDLE);
    assign tx_busy  = baud_en;
    assign fifo_pop = (state == ST_IDLE) && !fifo_empty;
    assign bit_end  = tick && (tick_cnt == TICK_LAST);

    baud_tick_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .en   (baud_en),
        .tick (tick)
    );

    always_comb begin
        state_n    = state;
        shift_n    = shift;
        tick_cnt_n = tick_cnt;
        bit_cnt_n  = bit_cnt;
        done_n     = 1'b0;
        if (tick) begin
            tick_cnt_n = bit_end ? '0 : tick_cnt + 1'b1;
        end
        case (state)
            ST_IDLE: begin
                tick_cnt_n = '0;
                bit_cnt_n  = '0;
                if (fifo_pop) begin
                    shift_n = fifo_rdata;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_n   = ST_DATA;
                    bit_cnt_n = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_n = {1'b0, shift[DATA_BITS-1:1]};
                    if (bit_cnt == BIT_LAST) begin
                        state_n   = ST_STOP;
                        bit_cnt_n = '0;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // tx follows the next state so the start bit appears on the popping edge.
    always_comb begin
        tx_n = 1'b1;
        if (state_n == ST_START) begin
            tx_n = 1'b0;
        end else if (state_n == ST_DATA) begin
            tx_n = shift_n[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            shift    <= '0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            tick_cnt <= tick_cnt_n;
            bit_cnt  <= bit_cnt_n;
            tx       <= tx_n;
            tx_done  <= done_n;
        end
    end

endmodule
